ball_motion: RTL
================

# ball_motion

Per-frame animation controller for the metaballs demo. It sits upstream of the `metaballs` renderer and drives the positions of three balls, plus a frame counter, from the `v_sync` output of the VGA timing generator. On each vertical sync it advances every ball by its velocity and bounces balls off a margin-inset screen boundary. All updates occur during vertical blanking, so the renderer never sees a ball move mid-frame.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible width in pixels
- `V_ACTIVE`, 480, visible height in lines
- `MARGIN`, 32, keep-out distance from each edge; x range [MARGIN, H_ACTIVE-MARGIN], y range [MARGIN, V_ACTIVE-MARGIN]

Ports:
- `clk`  in  1  pixel clock; the only clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `v_sync`  in  1  vertical sync from the VGA timing generator, active-low, synchronous to `clk`
- `pause`  in  1  high: frame ticks are ignored and positions freeze
- `speed`  in  2  velocity shift: step = vel << speed (1x/2x/4x/8x)
- `ball_x`  out  30  packed {b2,b1,b0}, 10-bit unsigned x per ball
- `ball_y`  out  30  packed {b2,b1,b0}, 10-bit unsigned y per ball
- `frame_count`  out  8  count of processed frames, wraps 255→0
- `update_done`  out  1  one-cycle pulse after all three balls are updated

## Operation
- Edge detect: register `vs_d` holds the previous `v_sync` sample; reset value is 0.
  - tick = `vs_d` & ~`v_sync` & ~`pause` & (state==IDLE).
  - Because `vs_d` resets to 0, a `v_sync` held low at reset release produces no tick.
- State machine IDLE → UPD0 → UPD1 → UPD2 → IDLE.
  - IDLE leaves only on tick.
  - UPDn writes ball n and advances unconditionally.
  - Ticks and `pause` changes during UPD0–UPD2 are ignored. A started sequence always completes.
- Per-ball state: pos_x, pos_y (10-bit unsigned); vel_x, vel_y (4-bit signed, never 0).
- Per-axis update, in 12-bit signed arithmetic:
  - step = sign-extend(vel) << speed, range −64..+56.
  - sum = pos + step.
  - If vel>0 and sum ≥ MAX: pos ← MAX, vel ← −vel.
  - Else if vel<0 and sum ≤ MIN: pos ← MIN, vel ← −vel.
  - Else pos ← sum[9:0].
  - MIN = MARGIN. MAX = H_ACTIVE−MARGIN for x, V_ACTIVE−MARGIN for y.
  - A position landing exactly on a bound counts as a bounce.
- Reset values:
  - b0 (160,120), vel (+3,+2)
  - b1 (320,240), vel (−2,+3)
  - b2 (480,360), vel (+1,−4)
  - `frame_count`=0, `update_done`=0, state IDLE.
- `frame_count` increments by 1 at the end of every completed sequence. It does not increment while paused.

## Timing
- E0 is the first rising edge at which `v_sync` is sampled 0 while `vs_d`=1 and tick conditions hold.
  - E0: state → UPD0.
  - E1: ball0 x/y/vel registered; state → UPD1.
  - E2: ball1 registered; state → UPD2.
  - E3: ball2 registered, `frame_count` += 1, `update_done` ← 1; state → IDLE.
  - E4: `update_done` ← 0.
- Latency from sync fall to last position change is 4 edges. This is far inside vertical blanking.
- All outputs come directly from registers; no combinational path from input to output.
- Reset assertion mid-sequence returns every output to its reset value immediately, without waiting for a clock edge. Any partial update is discarded.
- `v_sync` pulse width is irrelevant. Only one tick per falling edge.

## Test plan
- Reset, then one `v_sync` high→low with `speed`=0 → at E3: b0=(163,122), b1=(318,243), b2=(481,356), `frame_count`=1, `update_done` high exactly one cycle (E3–E4).
- Hold `v_sync` low through reset release, then keep it low for 100 cycles → no tick: positions at reset values, `frame_count`=0.
- `speed`=3, 16 frames → b2.x=608 (480+8·16 hits MAX exactly) with vel_x=−1; frame 17 → b2.x=600.
- `speed`=0, 82 frames → b2.y=32 (360−4·82 clamps at MIN), vel_y=+4; next frame → b2.y=36.
- `pause`=1 for 5 sync pulses, then `pause` raised during UPD1 of a running sequence → paused frames change nothing; the interrupted sequence completes and `frame_count` increments once.
- Assert `rst_n`=0 between E1 and E2 of a sequence → all outputs at reset values immediately. The next sync after release produces the first-frame values from scenario 1.

Source files
------------

// File: rtl/ball_motion.sv
// Per-frame animation controller: moves three balls and bounces them inside a margin-inset screen.
// Latency: sync fall edge E0 starts the sequence, balls 0/1/2 land on E1/E2/E3, update_done pulses E3-E4.
// No backpressure: a started three-cycle update sequence always runs to completion.
module ball_motion #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int MARGIN   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        v_sync,
  input  logic        pause,
  input  logic [1:0]  speed,
  output logic [29:0] ball_x,
  output logic [29:0] ball_y,
  output logic [7:0]  frame_count,
  output logic        update_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UPD0 = 2'd1;
  localparam logic [1:0] S_UPD1 = 2'd2;
  localparam logic [1:0] S_UPD2 = 2'd3;

  localparam logic signed [11:0] P_MIN  = 12'(MARGIN);
  localparam logic signed [11:0] X_MAX  = 12'(H_ACTIVE - MARGIN);
  localparam logic signed [11:0] Y_MAX  = 12'(V_ACTIVE - MARGIN);

  logic              vs_q;
  logic [1:0]        state_q, state_d;
  logic [7:0]        fc_q;
  logic              done_q;
  logic [2:0][9:0]   pos_x_q, pos_y_q;
  logic [2:0][3:0]   vel_x_q, vel_y_q;
  logic              tick;
  logic [1:0]        idx;
  logic [9:0]        cur_px, cur_py, new_px, new_py;
  logic [3:0]        cur_vx, cur_vy, new_vx, new_vy;

  // One axis of motion: returns {new_vel, new_pos}. Landing exactly on a bound is a bounce.
  function automatic logic [13:0] axis_step(input logic [9:0] pos, input logic [3:0] vel,
                                             input logic [1:0] spd, input logic signed [11:0] lim_max);
    logic signed [11:0] step;
    logic signed [11:0] sum;
    logic [3:0]         neg_vel;
    step    = $signed({{8{vel[3]}}, vel}) <<< spd;
    sum     = $signed({2'b00, pos}) + step;
    neg_vel = 4'd0 - vel;
    if (!vel[3] && (sum >= lim_max))
      axis_step = {neg_vel, lim_max[9:0]};
    else if (vel[3] && (sum <= P_MIN))
      axis_step = {neg_vel, P_MIN[9:0]};
    else
      axis_step = {vel, sum[9:0]};
  endfunction

  // Falling-edge tick detection and the IDLE->UPD0->UPD1->UPD2 sequencer.
  always_comb begin
    tick    = vs_q & ~v_sync & ~pause & (state_q == S_IDLE);
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = tick ? S_UPD0 : S_IDLE;
      S_UPD0:  state_d = S_UPD1;
      S_UPD1:  state_d = S_UPD2;
      default: state_d = S_IDLE;
    endcase
  end

  // Select the ball being updated this cycle and compute its next position/velocity.
  always_comb begin
    case (state_q)
      S_UPD1:  idx = 2'd1;
      S_UPD2:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    cur_px = pos_x_q[0]; cur_py = pos_y_q[0]; cur_vx = vel_x_q[0]; cur_vy = vel_y_q[0];
    case (idx)
      2'd1: begin cur_px = pos_x_q[1]; cur_py = pos_y_q[1]; cur_vx = vel_x_q[1]; cur_vy = vel_y_q[1]; end
      2'd2: begin cur_px = pos_x_q[2]; cur_py = pos_y_q[2]; cur_vx = vel_x_q[2]; cur_vy = vel_y_q[2]; end
      default: ;
    endcase
    {new_vx, new_px} = axis_step(cur_px, cur_vx, speed, X_MAX);
    {new_vy, new_py} = axis_step(cur_py, cur_vy, speed, Y_MAX);
  end

  // Control registers: sync history, state, frame counter and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b0;
      state_q <= S_IDLE;
      fc_q    <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      vs_q    <= v_sync;
      state_q <= state_d;
      done_q  <= (state_q == S_UPD2);
      if (state_q == S_UPD2)
        fc_q <= fc_q + 8'd1;
    end
  end

  // Ball state: one ball written per update cycle, the others hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_q <= {10'd480, 10'd320, 10'd160};
      pos_y_q <= {10'd360, 10'd240, 10'd120};
      vel_x_q <= {4'b0001, 4'b1110, 4'b0011};
      vel_y_q <= {4'b1100, 4'b0011, 4'b0010};
    end else if (state_q != S_IDLE) begin
      pos_x_q[idx] <= new_px;
      pos_y_q[idx] <= new_py;
      vel_x_q[idx] <= new_vx;
      vel_y_q[idx] <= new_vy;
    end
  end

  assign ball_x      = pos_x_q;
  assign ball_y      = pos_y_q;
  assign frame_count = fc_q;
  assign update_done = done_q;

endmodule
